// File: rtl/stream_access_control.sv
// stream_access_control: PL-side access controller between the AXI-Stream
// video ports and the up-sampling core.
// - Gates the source and result streams on UPSTART.
// - Counts beats and generates the result tlast/tuser framing.
// - At end of frame, writes UPSTAT through the register-file PL write port.
// Optional build macro AC_TLAST_CHECK_EN adds input-row tlast checking with a
// sticky ac_err_tlast flag, which is reported in UPSTAT bit 2.
module stream_access_control #(
  parameter int CRF_DATA_WIDTH  = 32,
  parameter int CRF_ADDR_WIDTH  = 32,
  parameter int AXIS_DATA_WIDTH = 24,
  parameter int SRC_WIDTH       = 960,
  parameter int SRC_HEIGHT      = 540,
  parameter int SCALE           = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       crf_ac_UPSTART,
  input  logic                       crf_ac_UPEND,
  input  logic                       crf_ac_wbusy,
  input  logic [CRF_DATA_WIDTH-1:0]  crf_ac_UPINHSKCNT,
  output logic                       ac_crf_wrt,
  output logic [CRF_ADDR_WIDTH-1:0]  ac_crf_waddr,
  output logic [CRF_DATA_WIDTH-1:0]  ac_crf_wdata,
  output logic                       ac_crf_axisi_tvalid,
  output logic                       ac_crf_axisi_tready,
  output logic                       ac_crf_axiso_tvalid,
  output logic                       ac_crf_axiso_tready,
  output logic                       ac_crf_processing,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tuser,
  output logic                       ac_up_tvalid,
  input  logic                       up_ac_tready,
  output logic [AXIS_DATA_WIDTH-1:0] ac_up_tdata,
  input  logic                       up_ac_tvalid,
  output logic                       ac_up_tready,
  input  logic [AXIS_DATA_WIDTH-1:0] up_ac_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  output logic                       ac_err_tlast
);

  localparam logic [31:0] IN_BEATS  = 32'(SRC_WIDTH * SRC_HEIGHT);
  localparam logic [31:0] OUT_LAST  = 32'(SRC_WIDTH * SRC_HEIGHT * SCALE * SCALE - 1);
  localparam logic [31:0] ROW_LAST  = 32'(SRC_WIDTH * SCALE - 1);

  typedef enum logic [1:0] {IDLE, PROC, FINISH, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] in_cnt, out_cnt, out_col;
  logic        in_en, out_en, in_hs, out_hs, start;
  logic        err_tlast;

  // The upstream source tuser and the debug handshake count are not consumed.
  logic unused_inputs;
  assign unused_inputs = s_axis_tuser ^ (^crf_ac_UPINHSKCNT);

  // Input is cut off once the frame's source beats are in; output runs all of PROC.
  assign in_en  = (state == PROC) && (in_cnt < IN_BEATS);
  assign out_en = (state == PROC);

  assign ac_up_tvalid  = s_axis_tvalid & in_en;
  assign s_axis_tready = up_ac_tready & in_en;
  assign m_axis_tvalid = up_ac_tvalid & out_en;
  assign ac_up_tready  = m_axis_tready & out_en;
  assign ac_up_tdata   = s_axis_tdata;
  assign m_axis_tdata  = up_ac_tdata;

  assign in_hs  = ac_up_tvalid & s_axis_tready;
  assign out_hs = m_axis_tvalid & ac_up_tready;

  assign m_axis_tuser = m_axis_tvalid & (out_cnt == 32'd0);
  assign m_axis_tlast = m_axis_tvalid & (out_col == ROW_LAST);

  assign ac_crf_axisi_tvalid = ac_up_tvalid;
  assign ac_crf_axisi_tready = s_axis_tready;
  assign ac_crf_axiso_tvalid = m_axis_tvalid;
  assign ac_crf_axiso_tready = ac_up_tready;
  assign ac_crf_processing   = (state == PROC);
  assign ac_err_tlast        = err_tlast;

  assign start = (state == IDLE) && (state_nxt == PROC);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and the UPSTAT write request raised in FINISH.
  always_comb begin
    state_nxt    = state;
    ac_crf_wrt   = 1'b0;
    ac_crf_waddr = '0;
    ac_crf_wdata = '0;
    case (state)
      IDLE: begin
        if (crf_ac_UPSTART && !crf_ac_UPEND) state_nxt = PROC;
      end
      PROC: begin
        if (!crf_ac_UPSTART)                      state_nxt = IDLE;
        else if (out_hs && (out_cnt == OUT_LAST)) state_nxt = FINISH;
      end
      FINISH: begin
        ac_crf_wrt      = 1'b1;
        ac_crf_wdata[1] = 1'b1;
        ac_crf_wdata[2] = err_tlast;
        if (!crf_ac_wbusy) state_nxt = DONE;
      end
      DONE: begin
        if (!crf_ac_UPSTART && !crf_ac_UPEND) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counters run only in PROC; outside it they are held at zero so
  // every frame (including one restarted after an abort) begins from zero.
  always_ff @(posedge clk) begin
    if (!rst_n || (state != PROC)) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      out_col <= '0;
    end else begin
      if (in_hs)  in_cnt  <= in_cnt + 32'd1;
      if (out_hs) out_cnt <= out_cnt + 32'd1;
      if (out_hs) out_col <= (out_col == ROW_LAST) ? 32'd0 : out_col + 32'd1;
    end
  end

`ifdef AC_TLAST_CHECK_EN
  localparam logic [31:0] IN_COL_LAST = 32'(SRC_WIDTH - 1);

  logic [31:0] in_col;

  // Input row position; tlast must mark exactly the last source column.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_col    <= '0;
      err_tlast <= 1'b0;
    end else if (start) begin
      in_col    <= '0;
      err_tlast <= 1'b0;
    end else if (in_hs) begin
      in_col <= (in_col == IN_COL_LAST) ? 32'd0 : in_col + 32'd1;
      if (s_axis_tlast != (in_col == IN_COL_LAST)) err_tlast <= 1'b1;
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast ^ start;
  assign err_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_stream_access_control.sv
// Directed bench for stream_access_control with a 4x2 source and 2x scale
// (8 input beats, 32 output beats, 8 output beats per row).
module tb_stream_access_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upstart, upend, wbusy;
  logic [31:0] inhskcnt;
  logic        wrt;
  logic [31:0] waddr, wdata;
  logic        axisi_tvalid, axisi_tready, axiso_tvalid, axiso_tready, processing;
  logic        s_tvalid, s_tready, s_tlast, s_tuser;
  logic [23:0] s_tdata;
  logic        up_tvalid_o, up_tready_i;
  logic [23:0] up_tdata_o;
  logic        up_tvalid_i, up_tready_o;
  logic [23:0] up_tdata_i;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [23:0] m_tdata;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  stream_access_control #(
    .CRF_DATA_WIDTH(32), .CRF_ADDR_WIDTH(32), .AXIS_DATA_WIDTH(24),
    .SRC_WIDTH(4), .SRC_HEIGHT(2), .SCALE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .crf_ac_UPSTART(upstart), .crf_ac_UPEND(upend), .crf_ac_wbusy(wbusy),
    .crf_ac_UPINHSKCNT(inhskcnt),
    .ac_crf_wrt(wrt), .ac_crf_waddr(waddr), .ac_crf_wdata(wdata),
    .ac_crf_axisi_tvalid(axisi_tvalid), .ac_crf_axisi_tready(axisi_tready),
    .ac_crf_axiso_tvalid(axiso_tvalid), .ac_crf_axiso_tready(axiso_tready),
    .ac_crf_processing(processing),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .ac_up_tvalid(up_tvalid_o), .up_ac_tready(up_tready_i), .ac_up_tdata(up_tdata_o),
    .up_ac_tvalid(up_tvalid_i), .ac_up_tready(up_tready_o), .up_ac_tdata(up_tdata_i),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .ac_err_tlast(err)
  );

  always #5 clk = ~clk;

  // in = {rst_n, upstart, upend, s_tvalid, up_tready, up_tvalid, m_tready}
  // ex = {processing, s_tready, ac_up_tvalid, m_tvalid, ac_up_tready, tuser, tlast, wrt}
  typedef struct packed {
    logic [6:0] in;
    logic [7:0] ex;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic streams_idle();
    s_tvalid = 0; s_tlast = 0; s_tuser = 0; s_tdata = '0;
    up_tready_i = 0; up_tvalid_i = 0; up_tdata_i = '0; m_tready = 0;
  endtask

  task automatic run_frame(input int busy, input bit stall, input bit bad, input string tag);
    int in_idx, out_idx, cyc;
    bit exp_err;
    logic [31:0] exp_wd;
    exp_err = 1'b0;
`ifdef AC_TLAST_CHECK_EN
    exp_err = bad;
`endif
    exp_wd = exp_err ? 32'h6 : 32'h2;
    upstart = 1; upend = 0; wbusy = 0;
    step();
    chk({tag, "_start_proc"}, processing, 1);
    chk({tag, "_start_err"}, err, 0);
    in_idx = 0; out_idx = 0; cyc = 0;
    while (cyc < 400) begin
      s_tvalid = 1;
      s_tdata = 24'(in_idx + 'h100);
      if (bad && in_idx < 4) s_tlast = (in_idx == 2);
      else                   s_tlast = (in_idx % 4 == 3);
      up_tready_i = 1; up_tvalid_i = 1;
      up_tdata_i = 24'(out_idx + 'h5000);
      m_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (wrt) break;
      if (in_idx >= 8) chk({tag, "_in_backpressure"}, s_tready, 0);
      if (m_tvalid && m_tready) begin
        chk($sformatf("%s_tuser[%0d]", tag, out_idx), m_tuser, (out_idx == 0));
        chk($sformatf("%s_tlast[%0d]", tag, out_idx), m_tlast, (out_idx % 8 == 7));
        chk($sformatf("%s_tdata[%0d]", tag, out_idx), m_tdata, 32'(out_idx + 'h5000));
        out_idx++;
      end
      if (axisi_tvalid && axisi_tready) begin
        chk($sformatf("%s_in_tdata[%0d]", tag, in_idx), up_tdata_o, 32'(in_idx + 'h100));
        in_idx++;
      end
      step();
      cyc++;
    end
    chk({tag, "_frame_in_time"}, (cyc < 400), 1);
    chk({tag, "_in_beats"}, in_idx, 8);
    chk({tag, "_out_beats"}, out_idx, 32);
    chk({tag, "_fin_waddr"}, waddr, 0);
    chk({tag, "_fin_wdata"}, wdata, exp_wd);
    chk({tag, "_fin_proc"}, processing, 0);
    chk({tag, "_fin_gated"}, {s_tready, m_tvalid}, 0);
    chk({tag, "_fin_err"}, err, exp_err);
    for (int k = 0; k < busy; k++) begin
      wbusy = 1;
      #1;
      chk($sformatf("%s_busy_wrt[%0d]", tag, k), wrt, 1);
      chk($sformatf("%s_busy_wdata[%0d]", tag, k), wdata, exp_wd);
      step();
    end
    wbusy = 0;
    #1;
    chk({tag, "_accept_wrt"}, wrt, 1);
    chk({tag, "_accept_wdata"}, wdata, exp_wd);
    step();
    chk({tag, "_done_wrt"}, wrt, 0);
    chk({tag, "_done_err"}, err, exp_err);
    upstart = 0; upend = 1;
    step();
    chk({tag, "_done_hold"}, {wrt, processing, s_tready}, 0);
    upend = 0;
    streams_idle();
    step();
  endtask

  initial begin
    int out_idx;
    rst_n = 0; upstart = 0; upend = 0; wbusy = 0; inhskcnt = '0;
    streams_idle();
    step(); step();

    // Reset state with every input asserted.
    upstart = 1; s_tvalid = 1; up_tready_i = 1; up_tvalid_i = 1; m_tready = 1;
    s_tdata = 24'hA5A5A5; up_tdata_i = 24'h5A5A5A;
    #1;
    chk("rst_outputs", {wrt, processing, s_tready, up_tvalid_o, m_tvalid, up_tready_o,
                        m_tuser, m_tlast, err}, 0);
    chk("rst_mirrors", {axisi_tvalid, axisi_tready, axiso_tvalid, axiso_tready}, 0);
    chk("rst_wbus", waddr | wdata, 0);
    chk("rst_pass_in", up_tdata_o, 32'hA5A5A5);
    chk("rst_pass_out", m_tdata, 32'h5A5A5A);
    step();

    tbl[0]  = {7'b0_1_0_1_1_1_1, 8'b0_0_0_0_0_0_0_0};
    tbl[1]  = {7'b1_1_1_1_1_1_1, 8'b0_0_0_0_0_0_0_0};
    tbl[2]  = {7'b1_0_0_1_1_1_1, 8'b0_0_0_0_0_0_0_0};
    tbl[3]  = {7'b1_1_0_1_1_1_1, 8'b0_0_0_0_0_0_0_0};
    tbl[4]  = {7'b1_1_0_1_1_1_1, 8'b1_1_1_1_1_1_0_0};
    tbl[5]  = {7'b1_1_0_1_0_1_0, 8'b1_0_1_1_0_0_0_0};
    tbl[6]  = {7'b1_1_0_0_1_0_1, 8'b1_1_0_0_1_0_0_0};
    tbl[7]  = {7'b1_0_0_1_1_1_1, 8'b1_1_1_1_1_0_0_0};
    tbl[8]  = {7'b1_0_0_1_1_1_1, 8'b0_0_0_0_0_0_0_0};
    tbl[9]  = {7'b1_1_0_1_1_1_1, 8'b0_0_0_0_0_0_0_0};
    tbl[10] = {7'b1_1_0_1_1_1_1, 8'b1_1_1_1_1_1_0_0};

    for (int i = 0; i < 11; i++) begin
      {rst_n, upstart, upend, s_tvalid, up_tready_i, up_tvalid_i, m_tready} = tbl[i].in;
      #1;
      chk($sformatf("vec%0d", i),
          {processing, s_tready, up_tvalid_o, m_tvalid, up_tready_o, m_tuser, m_tlast, wrt},
          tbl[i].ex);
      step();
    end

    // Reset in the middle of a frame: frame abandoned without a write.
    rst_n = 0;
    step();
    rst_n = 1; upstart = 0;
    #1;
    chk("midrst_idle", {processing, wrt, s_tready, m_tvalid}, 0);
    streams_idle();
    step();
    chk("midrst_nowrite", wrt, 0);

    run_frame(0, 1'b0, 1'b0, "f1");
    run_frame(5, 1'b1, 1'b0, "f2_busy");

    // PS abort after 12 output beats.
    upstart = 1; upend = 0;
    step();
    chk("ab_proc", processing, 1);
    out_idx = 0;
    for (int c = 0; c < 50 && out_idx < 12; c++) begin
      s_tvalid = 1; up_tready_i = 1; up_tvalid_i = 1; m_tready = 1;
      #1;
      if (m_tvalid && m_tready) out_idx++;
      step();
    end
    chk("ab_beats", out_idx, 12);
    upstart = 0; m_tready = 0;
    step();
    m_tready = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("ab_gated[%0d]", c), {processing, s_tready, up_tvalid_o, m_tvalid, up_tready_o, wrt}, 0);
      step();
    end
    streams_idle();
    run_frame(0, 1'b1, 1'b0, "f3_restart");

    run_frame(0, 1'b0, 1'b1, "f4_badtlast");
    run_frame(0, 1'b0, 1'b0, "f5_clean");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_access_control.md
Name: stream_access_control

Overview:
- PL-side access controller between the AXI-Stream video ports and the up-sampling core.
- Gates input and output streams on the UPSTART bit of the configuration register file and counts source and result beats.
- Generates output tlast/tuser framing.
- At end of frame, writes UPSTAT through the register file's PL write port (clear UPSTART, set UPEND), which raises the done interrupt.

Parameters:
- CRF_DATA_WIDTH, 32, register file data width
- CRF_ADDR_WIDTH, 32, register file address width
- AXIS_DATA_WIDTH, 24, pixel width (RGB888)
- SRC_WIDTH, 960, source pixels per row
- SRC_HEIGHT, 540, source rows
- SCALE, 4, up-scaling factor per axis; output beats = SRC_WIDTH*SRC_HEIGHT*SCALE*SCALE

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- crf_ac_UPSTART  in  1  UPSTAT[0]
- crf_ac_UPEND  in  1  UPSTAT[1]
- crf_ac_wbusy  in  1  register file busy with a PS write; PL write is ignored while high
- crf_ac_UPINHSKCNT  in  CRF_DATA_WIDTH  input handshake count (debug compare only)
- ac_crf_wrt  out  1  PL write request
- ac_crf_waddr  out  CRF_ADDR_WIDTH  PL write address
- ac_crf_wdata  out  CRF_DATA_WIDTH  PL write data
- ac_crf_axisi_tvalid / ac_crf_axisi_tready  out  1 each  gated input-stream handshake mirrors
- ac_crf_axiso_tvalid / ac_crf_axiso_tready  out  1 each  gated output-stream handshake mirrors
- ac_crf_processing  out  1  high in PROC
- s_axis_tvalid in 1; s_axis_tready out 1; s_axis_tdata in AXIS_DATA_WIDTH; s_axis_tlast in 1; s_axis_tuser in 1  source stream
- ac_up_tvalid out 1; up_ac_tready in 1; ac_up_tdata out AXIS_DATA_WIDTH  to core
- up_ac_tvalid in 1; ac_up_tready out 1; up_ac_tdata in AXIS_DATA_WIDTH  from core
- m_axis_tvalid out 1; m_axis_tready in 1; m_axis_tdata out AXIS_DATA_WIDTH; m_axis_tlast out 1; m_axis_tuser out 1  result stream
- ac_err_tlast  out  1  sticky framing error

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, all counters 0, ac_err_tlast 0. Every output is 0 except the data pass-throughs. Reset mid-frame abandons the frame with no UPSTAT write.
- States and transitions:
  - IDLE -> PROC when UPSTART=1 & UPEND=0.
  - PROC -> FINISH when the last output beat handshakes (out_cnt == OUT_BEATS-1 & m_axis_tvalid & m_axis_tready).
  - PROC -> IDLE if UPSTART drops (PS abort); counters clear.
  - FINISH -> DONE on the cycle ac_crf_wrt=1 & crf_ac_wbusy=0.
  - DONE -> IDLE when UPSTART=0 & UPEND=0 (PS cleared UPSTAT).
- FINISH outputs: ac_crf_wrt=1, waddr=0, wdata=32'h2 (UPEND=1, UPSTART=0). Held until accepted; stalls indefinitely while wbusy=1. The outputs are 0 in all other states.
- Stream gating, combinational, zero latency:
  - in_en = (state==PROC) & (in_cnt < IN_BEATS); out_en = (state==PROC).
  - ac_up_tvalid = s_axis_tvalid & in_en; s_axis_tready = up_ac_tready & in_en.
  - m_axis_tvalid = up_ac_tvalid & out_en; ac_up_tready = m_axis_tready & out_en.
  - tdata passes straight through.
- Mirrors equal the gated valid/ready pairs. ac_crf_processing = (state==PROC).
- Counters, 32-bit, increment on gated handshakes:
  - in_cnt, saturates at IN_BEATS.
  - out_cnt.
  - out_col, wraps at SRC_WIDTH*SCALE-1 -> 0.
  - All cleared on entry to PROC from IDLE.
- m_axis_tuser = 1 when out_cnt==0. m_axis_tlast = 1 when out_col == SRC_WIDTH*SCALE-1. Both are qualified by m_axis_tvalid.
- Simultaneous input and output handshakes in one cycle both count. The last-input and last-output handshake can coincide.
- Input beats offered after IN_BEATS are back-pressured (tready=0) until the next frame.

Optional Feature:
- Macro: AC_TLAST_CHECK_EN.
- Defined:
  - An input column counter checks s_axis_tlast on every input handshake.
  - tlast must equal (in_col == SRC_WIDTH-1). Any mismatch sets ac_err_tlast, sticky until IDLE->PROC.
  - FINISH writes wdata=32'h6 (bit 2 = error) when ac_err_tlast=1.
- Undefined: s_axis_tlast is ignored, ac_err_tlast is tied 0, and FINISH always writes 32'h2.

Test Plan:
- Params SRC_WIDTH=4, SRC_HEIGHT=2, SCALE=2 (IN=8, OUT=32, output row 8 beats). UPSTART=1 -> processing=1 next cycle. 8 input and 32 output beats flow. m_axis_tlast on beats 7, 15, 23, 31; tuser on beat 0. Then wrt=1, waddr=0, wdata=2 for one cycle; state DONE.
- crf_ac_wbusy held 1 for 5 cycles at FINISH -> wrt stays 1 for 6 cycles with stable data; write completes on the first wbusy=0 cycle.
- 10 input beats offered -> only 8 accepted. s_axis_tready=0 after the 8th. The ac_crf_axisi handshake mirrors show exactly 8 handshakes.
- UPSTART cleared after 12 output beats -> IDLE next cycle, tready/tvalid gated to 0, no PL write. A restart yields tuser on the first beat.
- Random m_axis_tready stalls -> no beat lost or duplicated; tlast positions unchanged.
- AC_TLAST_CHECK_EN defined, tlast on input beat 2 instead of 3 -> ac_err_tlast=1 and FINISH writes wdata=32'h6. Undefined: wdata=32'h2, ac_err_tlast=0.
